dmem_arbiter: RTL

- Shares the single-port word-addressed data memory between two requesters: req0 is the CPU MEM stage and req1 is the debug/DMA loader.
- Arbitrates with a round-robin pointer and sequences each access through a small FSM.
- Drives the memory's op/address/writevalue inputs and returns load data through a registered response with a one-cycle ack pulse.
- Sits between the pipeline MEM stage, the loader and the data memory instance.

---
 rtl/dmem_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU MEM stage
// (req0) and the debug/DMA loader (req1) using round-robin arbitration.
// Each access is sequenced IDLE -> ACCESS -> DONE and acknowledged by a
// one-cycle ack pulse. Load data comes back through a registered rdata.
// Optional feature macro: DMEM_ARB_ALIGN_CHECK_EN. It adds the `misalign`
// output and turns accesses with addr[1:0] != 0 into non-memory accesses.
module dmem_arbiter #(
  parameter logic [5:0] LW_OP   = 6'h23,
  parameter logic [5:0] SW_OP   = 6'h2b,
  parameter logic [5:0] IDLE_OP = 6'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic [5:0]  op0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic [5:0]  op1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic [31:0] rdata1,
  output logic [5:0]  mem_op,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writevalue,
  input  logic [31:0] mem_readvalue,
  output logic        busy,
  output logic        owner
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        rr_ptr;
  logic        grant;
  logic        grant_sel;
  logic [5:0]  sel_op;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_bad;
  logic [5:0]  lat_op;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_bad;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic        sel_mis;
  logic        lat_mis;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and grant decision; in DONE only the other requester is eligible
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    grant_sel  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req0 && req1) begin
          grant     = 1'b1;
          grant_sel = rr_ptr;
        end else if (req0) begin
          grant     = 1'b1;
          grant_sel = 1'b0;
        end else if (req1) begin
          grant     = 1'b1;
          grant_sel = 1'b1;
        end
        if (grant) begin
          next_state = S_ACCESS;
        end
      end
      S_ACCESS: begin
        next_state = S_DONE;
      end
      S_DONE: begin
        if (owner ? req0 : req1) begin
          grant      = 1'b1;
          grant_sel  = ~owner;
          next_state = S_ACCESS;
        end else begin
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Select the granted requester's inputs and classify the access
  always_comb begin
    sel_op    = grant_sel ? op1 : op0;
    sel_addr  = grant_sel ? addr1 : addr0;
    sel_wdata = grant_sel ? wdata1 : wdata0;
    sel_bad   = (sel_op != LW_OP) && (sel_op != SW_OP);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    sel_mis   = (sel_addr[1:0] != 2'b00);
    sel_bad   = sel_bad || sel_mis;
`endif
  end

  // Grant latching, load capture, ack pulse and round-robin pointer update
  always_ff @(posedge clock) begin
    if (reset) begin
      owner     <= 1'b0;
      rr_ptr    <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      lat_op    <= IDLE_OP;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_bad   <= 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      lat_mis   <= 1'b0;
      misalign  <= 1'b0;
`endif
    end else begin
      if (grant) begin
        owner     <= grant_sel;
        lat_op    <= sel_op;
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
        lat_bad   <= sel_bad;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        lat_mis   <= sel_mis;
`endif
      end
      if (state == S_ACCESS) begin
        if (owner) begin
          ack1 <= 1'b1;
        end else begin
          ack0 <= 1'b1;
        end
        rr_ptr <= ~owner;
        if (lat_bad) begin
          if (owner) begin
            rdata1 <= '0;
          end else begin
            rdata0 <= '0;
          end
        end else if (lat_op == LW_OP) begin
          if (owner) begin
            rdata1 <= mem_readvalue;
          end else begin
            rdata0 <= mem_readvalue;
          end
        end
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        misalign <= lat_mis;
`endif
      end else if (state == S_DONE) begin
        ack0 <= 1'b0;
        ack1 <= 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        misalign <= 1'b0;
`endif
      end
    end
  end

  // Memory drive: op only during a legal ACCESS, gated by reset so no store commits on a reset edge
  always_comb begin
    mem_op = IDLE_OP;
    if (!reset && (state == S_ACCESS) && !lat_bad) begin
      mem_op = lat_op;
    end
  end

  assign mem_address    = lat_addr;
  assign mem_writevalue = lat_wdata;
  assign busy           = (state != S_IDLE);

endmodule
